// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, Status/Cause field positions,
// FSM state enum, default handler vector and register packing helpers.
package cp0_pkg;

  localparam int unsigned CP0_AW   = 5;
  localparam int unsigned CP0_DW   = 32;
  localparam int unsigned IM_W     = 8;
  localparam int unsigned EXC_W    = 5;

  localparam logic [CP0_AW-1:0] CP0_STATUS = 5'd12;
  localparam logic [CP0_AW-1:0] CP0_CAUSE  = 5'd13;
  localparam logic [CP0_AW-1:0] CP0_EPC    = 5'd14;

  // Status fields
  localparam int unsigned ST_IE    = 0;
  localparam int unsigned ST_EXL   = 1;
  localparam int unsigned ST_IM_LO = 8;
  localparam int unsigned ST_IM_HI = 15;

  // Cause fields
  localparam int unsigned CA_EXC_LO = 2;
  localparam int unsigned CA_EXC_HI = 6;
  localparam int unsigned CA_IP_LO  = 8;
  localparam int unsigned CA_IP_HI  = 15;

  localparam logic [CP0_DW-1:0] CP0_VECTOR_PC_DEFAULT = 32'h0000_0008;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_COMMIT = 2'd2
  } cp0_state_e;

  // Status image: unimplemented bits read as zero.
  function automatic logic [CP0_DW-1:0] pack_status(input logic ie, input logic exl,
                                                    input logic [IM_W-1:0] im);
    return {16'h0000, im, 6'b000000, exl, ie};
  endfunction

  // Cause image: IP in [15:8], ExcCode in [6:2].
  function automatic logic [CP0_DW-1:0] pack_cause(input logic [IM_W-1:0] ip,
                                                   input logic [EXC_W-1:0] exccode);
    return {16'h0000, ip, 1'b0, exccode, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_irq_sync.sv
// Interrupt line synchronizer.
// Build option CP0_IRQ_SYNC_EN: defined -> two-flop synchronizer (2-cycle
// latency); undefined -> single capture register (1-cycle latency).
// Ports: clk, resetn (async active-low), d (raw irq lines), q (synchronized).
module cp0_irq_sync
  import cp0_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

`ifdef CP0_IRQ_SYNC_EN
  logic [W-1:0] meta;

  // First stage may go metastable; only the second stage is consumed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end
`endif

endmodule

// File: rtl/cp0_intr_ctrl.sv
// CP0 interrupt controller: Status/Cause/EPC registers, mtc0/mfc0 access,
// interrupt request/acknowledge handshake and eret handling.
// Build option CP0_IRQ_SYNC_EN selects the irq synchronizer depth.
// Ports:
//   clk, resetn            clock, async active-low reset
//   irq[NIRQ]              external level interrupts (async)
//   mtc0, cp0_addr, wdata  register write port; rdata is the combinational read
//   pc_id                  PC captured into EPC when an interrupt is taken
//   eret                   return-from-exception strobe (clears EXL)
//   exc_req / exc_ack      interrupt request to pipeline and its acceptance
//   vector_pc, epc_out     handler address and return address
//   status_out, cause_out  live register images
module cp0_intr_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] VECTOR_PC = CP0_VECTOR_PC_DEFAULT,
  parameter int unsigned NIRQ      = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NIRQ-1:0] irq,
  input  logic            mtc0,
  input  logic [4:0]      cp0_addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [31:0]     pc_id,
  input  logic            eret,
  output logic            exc_req,
  input  logic            exc_ack,
  output logic [31:0]     vector_pc,
  output logic [31:0]     epc_out,
  output logic [31:0]     status_out,
  output logic [31:0]     cause_out
);

  cp0_state_e       state;
  logic             ie;
  logic             exl;
  logic [IM_W-1:0]  im;
  logic [EXC_W-1:0] exccode;
  logic [31:0]      epc;
  logic [NIRQ-1:0]  irq_s;
  logic [IM_W-1:0]  ip;
  logic             irq_pending;

  cp0_irq_sync #(.W(NIRQ)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (irq),
    .q      (irq_s)
  );

  assign ip          = IM_W'(irq_s);
  assign irq_pending = ie && !exl && (|(ip & im));

  // Handshake FSM; exc_req is registered and high exactly while in REQ.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      exc_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (irq_pending) begin
            state   <= S_REQ;
            exc_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (exc_ack) begin
            state   <= S_COMMIT;
            exc_req <= 1'b0;
          end
        end
        S_COMMIT: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          exc_req <= 1'b0;
        end
      endcase
    end
  end

  // Register file; the commit cycle owns Status/EPC outright, so any
  // concurrent mtc0 or eret is dropped in that cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ie      <= 1'b0;
      exl     <= 1'b0;
      im      <= '0;
      exccode <= '0;
      epc     <= '0;
    end else if (state == S_COMMIT) begin
      epc     <= pc_id;
      exl     <= 1'b1;
      exccode <= '0;
    end else begin
      if (mtc0 && (cp0_addr == CP0_STATUS)) begin
        ie  <= wdata[ST_IE];
        exl <= wdata[ST_EXL];
        im  <= wdata[ST_IM_HI:ST_IM_LO];
      end
      if (mtc0 && (cp0_addr == CP0_EPC)) begin
        epc <= wdata;
      end
      // eret wins over a same-cycle Status write for the EXL bit.
      if (eret) begin
        exl <= 1'b0;
      end
    end
  end

  assign status_out = pack_status(ie, exl, im);
  assign cause_out  = pack_cause(ip, exccode);
  assign epc_out    = epc;
  assign vector_pc  = VECTOR_PC;

  // mfc0 read mux.
  always_comb begin
    rdata = 32'h0;
    case (cp0_addr)
      CP0_STATUS: rdata = status_out;
      CP0_CAUSE:  rdata = cause_out;
      CP0_EPC:    rdata = epc;
      default:    rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
module tb_cp0_intr_ctrl;

  localparam int unsigned NIRQ = 8;
  localparam logic [31:0] VPC  = 32'h0000_0008;
`ifdef CP0_IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NIRQ-1:0] irq = '0;
  logic            mtc0 = 1'b0;
  logic [4:0]      cp0_addr = 5'd0;
  logic [31:0]     wdata = 32'h0;
  logic [31:0]     rdata;
  logic [31:0]     pc_id = 32'h0;
  logic            eret = 1'b0;
  logic            exc_req;
  logic            exc_ack = 1'b0;
  logic [31:0]     vector_pc, epc_out, status_out, cause_out;

  int errors = 0;
  int checks = 0;

  cp0_intr_ctrl #(.VECTOR_PC(VPC), .NIRQ(NIRQ)) dut (
    .clk(clk), .resetn(resetn), .irq(irq), .mtc0(mtc0), .cp0_addr(cp0_addr),
    .wdata(wdata), .rdata(rdata), .pc_id(pc_id), .eret(eret),
    .exc_req(exc_req), .exc_ack(exc_ack), .vector_pc(vector_pc),
    .epc_out(epc_out), .status_out(status_out), .cause_out(cause_out)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register contents plus "request raised"
  // and "commit due on this edge" flags; IP is irq delayed by LAT edges.
  bit          m_ie, m_exl, m_req, m_commit;
  logic [7:0]  m_im;
  logic [31:0] m_epc;
  logic [7:0]  m_hist [LAT];

  task automatic model_reset();
    m_ie = 0; m_exl = 0; m_req = 0; m_commit = 0; m_im = '0; m_epc = '0;
    for (int i = 0; i < LAT; i++) m_hist[i] = '0;
  endtask

  function automatic logic [31:0] m_status();
    return {16'h0, m_im, 6'b0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {16'h0, m_hist[LAT-1], 8'h0};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd12) return m_status();
    if (a == 5'd13) return m_cause();
    if (a == 5'd14) return m_epc;
    return 32'h0;
  endfunction

  // Advance one clock edge, updating the model from pre-edge inputs.
  task automatic tick();
    logic [7:0]  s_irq;
    logic        s_mtc0, s_eret, s_ack;
    logic [4:0]  s_addr;
    logic [31:0] s_wdata, s_pc;
    bit          take;
    s_irq = 8'(irq); s_mtc0 = mtc0; s_eret = eret; s_ack = exc_ack;
    s_addr = cp0_addr; s_wdata = wdata; s_pc = pc_id;
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      take = !m_req && !m_commit && m_ie && !m_exl && ((m_hist[LAT-1] & m_im) != 8'h0);
      if (m_commit) begin
        m_epc = s_pc; m_exl = 1; m_commit = 0;
      end else begin
        if (s_mtc0 && s_addr == 5'd12) begin
          m_ie = s_wdata[0]; m_exl = s_wdata[1]; m_im = s_wdata[15:8];
        end
        if (s_mtc0 && s_addr == 5'd14) m_epc = s_wdata;
        if (s_eret) m_exl = 0;
        if (m_req && s_ack) begin
          m_req = 0; m_commit = 1;
        end else if (take) begin
          m_req = 1;
        end
      end
      for (int i = LAT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = s_irq;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] addrs [4];
    addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14; addrs[3] = 5'd3;
    resetn = 0; model_reset(); #1;
    for (int i = 0; i < 4; i++) begin
      cp0_addr = addrs[i]; #1;
      checks++;
      if (rdata !== 32'h0) begin
        errors++; $display("FAIL reset_rdata addr=%0d: got %h want 00000000", addrs[i], rdata);
      end
    end
    checks++;
    if (exc_req !== 1'b0) begin
      errors++; $display("FAIL reset_exc_req: got %b want 0", exc_req);
    end
    checks++;
    if (vector_pc !== VPC) begin
      errors++; $display("FAIL vector_pc: got %h want %h", vector_pc, VPC);
    end
    @(negedge clk); resetn = 1;
    tick();
  endtask

  task automatic test_status_write();
    cp0_addr = 5'd12; mtc0 = 1; wdata = 32'h0000_FF03; tick(); mtc0 = 0;
    checks++;
    if (rdata !== 32'h0000_FF03 || m_status() !== 32'h0000_FF03) begin
      errors++; $display("FAIL status_write: got %h want 0000ff03", rdata);
    end
    mtc0 = 1; wdata = 32'hFFFF_FFFF; tick(); mtc0 = 0;
    checks++;
    if (rdata !== 32'h0000_FF03) begin
      errors++; $display("FAIL status_mask: got %h want 0000ff03", rdata);
    end
    cp0_addr = 5'd13; mtc0 = 1; wdata = 32'hFFFF_FFFF; tick(); mtc0 = 0;
    checks++;
    if (cause_out !== 32'h0 || rdata !== m_cause()) begin
      errors++; $display("FAIL cause_ro: got %h want %h", cause_out, m_cause());
    end
    cp0_addr = 5'd12; mtc0 = 1; wdata = 32'h0; tick(); mtc0 = 0;
  endtask

  task automatic test_handshake();
    bit seen;
    cp0_addr = 5'd12; mtc0 = 1; wdata = 32'h0000_0101; tick(); mtc0 = 0;
    irq = 8'h01; pc_id = 32'h0000_0040; seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      checks++;
      if (exc_req !== m_req) begin
        errors++; $display("FAIL hs_latency cyc=%0d: got %b want %b", i, exc_req, m_req);
      end
      seen = exc_req;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (exc_req !== 1'b1) begin
        errors++; $display("FAIL hs_hold k=%0d: got %b want 1", k, exc_req);
      end
      if (k < 2) tick();
    end
    exc_ack = 1; tick(); exc_ack = 0;
    checks++;
    if (exc_req !== 1'b0) begin
      errors++; $display("FAIL hs_drop: got %b want 0", exc_req);
    end
    tick();
    checks++;
    if (epc_out !== 32'h0000_0040 || status_out !== 32'h0000_0103 || exc_req !== 1'b0) begin
      errors++; $display("FAIL hs_commit: epc=%h status=%h req=%b want 00000040 00000103 0",
                         epc_out, status_out, exc_req);
    end
    irq = 8'h00;
    for (int i = 0; i <= LAT; i++) tick();
  endtask

  task automatic test_exl_eret();
    bit seen;
    cp0_addr = 5'd12; mtc0 = 1; wdata = 32'h0000_FF03; tick(); mtc0 = 0;
    irq = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (exc_req !== 1'b0) begin
        errors++; $display("FAIL exl_block cyc=%0d: got %b want 0", i, exc_req);
      end
    end
    checks++;
    if (cause_out !== 32'h0000_FF00) begin
      errors++; $display("FAIL cause_ip: got %h want 0000ff00", cause_out);
    end
    eret = 1; tick(); eret = 0;
    checks++;
    if (status_out !== 32'h0000_FF01) begin
      errors++; $display("FAIL eret_exl: got %h want 0000ff01", status_out);
    end
    seen = 0;
    for (int i = 0; i < LAT + 3 && !seen; i++) begin
      tick();
      seen = exc_req;
    end
    checks++;
    if (!seen || m_req != 1) begin
      errors++; $display("FAIL eret_req: got %b want 1", exc_req);
    end
  endtask

  task automatic test_commit_override();
    pc_id = 32'h1234_5678;
    exc_ack = 1; tick(); exc_ack = 0;
    cp0_addr = 5'd14; mtc0 = 1; wdata = 32'hDEAD_BEEF; tick(); mtc0 = 0;
    checks++;
    if (epc_out !== 32'h1234_5678 || rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL commit_override: got %h want 12345678", epc_out);
    end
    checks++;
    if (status_out !== 32'h0000_FF03) begin
      errors++; $display("FAIL commit_exl: got %h want 0000ff03", status_out);
    end
  endtask

  task automatic test_reset_midreq();
    eret = 1; tick(); eret = 0; tick();
    checks++;
    if (exc_req !== 1'b1) begin
      errors++; $display("FAIL midreq_setup: got %b want 1", exc_req);
    end
    irq = 8'h00;
    #2 resetn = 0; model_reset(); #1;
    checks++;
    if (exc_req !== 1'b0) begin
      errors++; $display("FAIL midreq_async: got %b want 0", exc_req);
    end
    tick();
    checks++;
    if (exc_req !== 1'b0 || epc_out !== 32'h0 || status_out !== 32'h0) begin
      errors++; $display("FAIL midreq_reset: req=%b epc=%h status=%h want 0 0 0",
                         exc_req, epc_out, status_out);
    end
    @(negedge clk); resetn = 1;
    tick();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        resetn = 0; model_reset(); #1;
        checks++;
        if (exc_req !== 1'b0 || status_out !== 32'h0) begin
          errors++; $display("FAIL rnd_reset n=%0d: req=%b status=%h", n, exc_req, status_out);
        end
        resetn = 1;
      end
      if ($urandom_range(0, 15) < 3) irq = NIRQ'($urandom);
      r = $urandom_range(0, 4);
      cp0_addr = (r == 0) ? 5'd12 : (r == 1) ? 5'd13 : (r == 2) ? 5'd14 :
                 (r == 3) ? 5'd0 : 5'($urandom);
      mtc0    = ($urandom_range(0, 5) == 0);
      wdata   = $urandom;
      eret    = ($urandom_range(0, 15) == 0);
      exc_ack = ($urandom_range(0, 3) == 0);
      pc_id   = $urandom;
      tick();
      checks++;
      if (exc_req !== m_req) begin
        errors++; $display("FAIL rnd_exc_req n=%0d: got %b want %b", n, exc_req, m_req);
      end
      checks++;
      if (status_out !== m_status()) begin
        errors++; $display("FAIL rnd_status n=%0d: got %h want %h", n, status_out, m_status());
      end
      checks++;
      if (cause_out !== m_cause()) begin
        errors++; $display("FAIL rnd_cause n=%0d: got %h want %h", n, cause_out, m_cause());
      end
      checks++;
      if (epc_out !== m_epc) begin
        errors++; $display("FAIL rnd_epc n=%0d: got %h want %h", n, epc_out, m_epc);
      end
      checks++;
      if (rdata !== m_read(cp0_addr)) begin
        errors++; $display("FAIL rnd_rdata n=%0d addr=%0d: got %h want %h",
                           n, cp0_addr, rdata, m_read(cp0_addr));
      end
    end
    mtc0 = 0; eret = 0; exc_ack = 0;
  endtask

  initial begin
    test_reset();
    test_status_write();
    test_handshake();
    test_exl_eret();
    test_commit_override();
    test_reset_midreq();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
